// File: rtl/led_matrix_pkg.sv
// ---------------------------------------------------------------------------
// led_matrix_pkg
//   Shared definitions for the 5x7 LED dot-matrix scan controller.
//   Matrix geometry, the scan state encoding, the row pattern type and a
//   one-hot row decode helper.
// ---------------------------------------------------------------------------
package led_matrix_pkg;

    localparam int ROWS       = 5;   // matrix rows, one-hot row drive
    localparam int COLS       = 7;   // column bits per row
    localparam int RIDX_W     = 3;   // row index width
    localparam int SLOT_UNITS = 16;  // brightness units per row slot

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SLOT
    } scan_state_t;

    typedef logic [COLS-1:0] row_pat_t;
    typedef logic [ROWS-1:0] row_sel_t;

    // One-hot row select for a row index; out-of-range indices decode to 0.
    function automatic row_sel_t row_onehot(input logic [RIDX_W-1:0] idx);
        row_sel_t sel;
        sel = '0;
        if (int'(idx) < ROWS) begin
            sel = row_sel_t'(1) << idx;
        end
        return sel;
    endfunction

endpackage

// File: rtl/led_matrix_scan_timer.sv
// ---------------------------------------------------------------------------
// scan_timer
//   Counters for the row scan: BLANK cycle counter, per-unit cycle counter
//   and the 4-bit unit-within-slot counter. Produces done strobes for the
//   FSM plus the unit index that will be current after the next clock edge,
//   so the top can register its row/column outputs in step with the state.
//
// Ports
//   i_clk        in   clock
//   i_rst_n      in   asynchronous active-low reset
//   i_clr        in   synchronous clear of all counters
//   i_blank      in   FSM is in BLANK (advance the blank counter)
//   i_slot       in   FSM is in SLOT  (advance unit/slot counters)
//   o_blank_done out  last BLANK cycle
//   o_slot_done  out  last cycle of the last unit of the slot
//   o_unit_nxt   out  slot-unit index valid after the coming edge
// ---------------------------------------------------------------------------
module scan_timer
    import led_matrix_pkg::*;
#(
    parameter int UNIT_CYCLES  = 3125,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_blank,
    input  logic       i_slot,
    output logic       o_blank_done,
    output logic       o_slot_done,
    output logic [3:0] o_unit_nxt
);

    localparam int UW = (UNIT_CYCLES  > 1) ? $clog2(UNIT_CYCLES)  : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    logic [BW-1:0] r_blank_cnt;
    logic [UW-1:0] r_unit_cnt;
    logic [3:0]    r_slot_unit;

    logic w_blank_last;
    logic w_unit_last;
    logic w_slot_last;

    assign w_blank_last = (r_blank_cnt == BW'(BLANK_CYCLES - 1));
    assign w_unit_last  = (r_unit_cnt  == UW'(UNIT_CYCLES - 1));
    assign w_slot_last  = (r_slot_unit == 4'(SLOT_UNITS - 1));

    assign o_blank_done = i_blank && w_blank_last;
    assign o_slot_done  = i_slot && w_unit_last && w_slot_last;

    // The slot-unit counter wraps to 0 at the end of every slot, so it is
    // already 0 when the FSM enters the next SLOT.
    always_comb begin
        o_unit_nxt = r_slot_unit;
        if (i_clr) begin
            o_unit_nxt = '0;
        end else if (i_slot && w_unit_last) begin
            o_unit_nxt = r_slot_unit + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blank_cnt <= '0;
            r_unit_cnt  <= '0;
            r_slot_unit <= '0;
        end else if (i_clr) begin
            r_blank_cnt <= '0;
            r_unit_cnt  <= '0;
            r_slot_unit <= '0;
        end else begin
            if (i_blank) begin
                r_blank_cnt <= w_blank_last ? '0 : r_blank_cnt + 1'b1;
            end
            if (i_slot) begin
                r_unit_cnt <= w_unit_last ? '0 : r_unit_cnt + 1'b1;
                if (w_unit_last) begin
                    r_slot_unit <= r_slot_unit + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_ctrl
//   Scan scheduler for the 5x7 LED dot matrix. Double-buffered frame store,
//   one row at a time with a dark blanking gap ahead of each row slot and
//   PWM brightness inside the slot. The back buffer is written through a
//   valid/ready port; a swap request is held until the next frame boundary
//   so a frame is never shown half-updated.
//
// Ports
//   CLOCK_50    in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   scan enable (0 = dark, scan held at row 0)
//   brightness  in   lit units per 16-unit row slot
//   wr_valid    in   back-buffer write request
//   wr_ready    out  back buffer accepts a write (no swap pending)
//   wr_row      in   target row of the write (>= ROWS is discarded)
//   wr_data     in   column pattern of the write
//   swap_req    in   pulse: show the back buffer from the next frame
//   swap_done   out  pulse in the cycle the buffers exchange
//   row         out  one-hot active-high row select
//   column      out  active-high column pattern of the selected row
//   frame_start out  pulse at entry to row 0 BLANK
// ---------------------------------------------------------------------------
module led_matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int UNIT_CYCLES  = 3125,
    parameter int BLANK_CYCLES = 500
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        brightness,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [RIDX_W-1:0] wr_row,
    input  logic [COLS-1:0]   wr_data,
    input  logic              swap_req,
    output logic              swap_done,
    output logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   column,
    output logic              frame_start
);

    // ---------------- state ----------------
    scan_state_t       r_state;
    logic [RIDX_W-1:0] r_ridx;
    logic [3:0]        r_bri;
    row_pat_t          r_buf [2][ROWS];
    logic              r_front;
    logic              r_swap_pending;

    logic              r_wr_ready;
    logic              r_swap_done;
    row_sel_t          r_row;
    row_pat_t          r_column;
    logic              r_frame_start;

    // ---------------- next-state wires ----------------
    scan_state_t       w_state_nxt;
    logic [RIDX_W-1:0] w_ridx_nxt;
    logic [3:0]        w_bri_nxt;
    logic              w_fs_nxt;
    logic              w_boundary;
    logic              w_swap_apply;
    logic              w_pending_nxt;
    logic              w_lit;
    row_pat_t          w_pat_nxt;
    row_sel_t          w_row_nxt;
    row_pat_t          w_col_nxt;
    logic              w_wr_fire;

    logic              w_clr;
    logic              w_in_blank;
    logic              w_in_slot;
    logic              w_blank_done;
    logic              w_slot_done;
    logic [3:0]        w_unit_nxt;

    assign w_clr      = ~en;
    assign w_in_blank = (r_state == BLANK);
    assign w_in_slot  = (r_state == SLOT);
    assign w_wr_fire  = wr_valid && r_wr_ready;

    scan_timer #(
        .UNIT_CYCLES  (UNIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .i_clk        (CLOCK_50),
        .i_rst_n      (rst_n),
        .i_clr        (w_clr),
        .i_blank      (w_in_blank),
        .i_slot       (w_in_slot),
        .o_blank_done (w_blank_done),
        .o_slot_done  (w_slot_done),
        .o_unit_nxt   (w_unit_nxt)
    );

    // ---------------- FSM next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_ridx_nxt  = r_ridx;
        w_bri_nxt   = r_bri;
        w_fs_nxt    = 1'b0;
        w_boundary  = 1'b0;

        if (!en) begin
            w_state_nxt = IDLE;
            w_ridx_nxt  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_ridx_nxt  = '0;
                    w_fs_nxt    = 1'b1;
                end
                BLANK: begin
                    if (w_blank_done) begin
                        w_state_nxt = SLOT;
                        w_bri_nxt   = brightness;
                    end
                end
                SLOT: begin
                    if (w_slot_done) begin
                        w_state_nxt = BLANK;
                        if (r_ridx == RIDX_W'(ROWS - 1)) begin
                            w_ridx_nxt = '0;
                            w_boundary = 1'b1;
                            w_fs_nxt   = 1'b1;
                        end else begin
                            w_ridx_nxt = r_ridx + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- swap and output decode ----------------
    always_comb begin
        // A request landing on the boundary cycle is honoured at that boundary.
        w_swap_apply  = ((r_state == IDLE) && r_swap_pending) ||
                        (w_boundary && (r_swap_pending || swap_req));
        w_pending_nxt = w_swap_apply ? 1'b0 : (r_swap_pending || swap_req);

        // Outputs are computed for the state after the edge, so the
        // registered row/column line up exactly with the SLOT cycles.
        // The front buffer is stable across any lit cycle: swaps only
        // happen on the way into BLANK or while IDLE.
        w_pat_nxt = '0;
        if (int'(w_ridx_nxt) < ROWS) begin
            w_pat_nxt = r_buf[r_front][w_ridx_nxt];
        end

        // An empty row pattern keeps the row driver off as well.
        w_lit = (w_state_nxt == SLOT) && (w_unit_nxt < w_bri_nxt) &&
                (w_pat_nxt != '0);

        w_row_nxt = '0;
        w_col_nxt = '0;
        if (w_lit) begin
            w_row_nxt = row_onehot(w_ridx_nxt);
            w_col_nxt = w_pat_nxt;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ridx  <= '0;
            r_bri   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ridx  <= w_ridx_nxt;
            r_bri   <= w_bri_nxt;
        end
    end

    // Write lands in the current back buffer on the same edge a swap may
    // commit it, so a write and swap_req together keep the write.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < ROWS; i++) begin
                    r_buf[b][i] <= '0;
                end
            end
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
        end else begin
            if (w_wr_fire && (int'(wr_row) < ROWS)) begin
                r_buf[~r_front][wr_row] <= wr_data;
            end
            r_front        <= r_front ^ w_swap_apply;
            r_swap_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ready    <= 1'b1;
            r_swap_done   <= 1'b0;
            r_row         <= '0;
            r_column      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_wr_ready    <= ~w_pending_nxt;
            r_swap_done   <= w_swap_apply;
            r_row         <= w_row_nxt;
            r_column      <= w_col_nxt;
            r_frame_start <= w_fs_nxt;
        end
    end

    assign wr_ready    = r_wr_ready;
    assign swap_done   = r_swap_done;
    assign row         = r_row;
    assign column      = r_column;
    assign frame_start = r_frame_start;

endmodule
